// File: rtl/pingpong_buf_pkg.sv
// Purpose: shared types and default sizes for the ping-pong buffer slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: bank_state_t per-bank state encoding, default word width and depth.
package pingpong_pkg;

    localparam int PP_DATA_W = 16;
    localparam int PP_DEPTH  = 8;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2
    } bank_state_t;

endpackage

// File: rtl/pingpong_buf_if.sv
// Purpose: producer/consumer handshake bundle for pingpong_buf.
// Latency: n/a (wires only).
// Backpressure: wr_ready throttles the producer, rd_ready throttles the buffer.
// Ports: wr_valid/wr_data/wr_ready, rd_valid/rd_data/rd_ready/rd_last, bank_full[1:0],
//        flush (present only when PINGPONG_FLUSH_EN is defined).
//        master = producer/consumer side, slave = buffer side.
interface pingpong_buf_if #(
    parameter int DATA_W = pingpong_pkg::PP_DATA_W
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              rd_last;
    logic [1:0]        bank_full;
`ifdef PINGPONG_FLUSH_EN
    logic              flush;

    modport master (
        output wr_valid, wr_data, rd_ready, flush,
        input  wr_ready, rd_valid, rd_data, rd_last, bank_full
    );
    modport slave (
        input  wr_valid, wr_data, rd_ready, flush,
        output wr_ready, rd_valid, rd_data, rd_last, bank_full
    );
`else
    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, rd_last, bank_full
    );
    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, rd_last, bank_full
    );
`endif
endinterface

// File: rtl/pingpong_buf_bank.sv
// Purpose: one DEPTH x DATA_W register bank, synchronous write, asynchronous read.
// Latency: write visible on rdata the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates we.
// Ports: clk, rst (async active-high, clears contents), we/waddr/wdata, raddr/rdata.
module pingpong_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pingpong_buf.sv
// Purpose: two-bank ping-pong buffer; producer fills one bank while consumer drains the other.
// Latency: last word of a bank written at edge N -> rd_valid with word 0 in the following cycle.
// Backpressure: wr_ready drops only when the write bank is still FULL; rd side stalls on rd_ready.
// Ports: clk, rst (async active-high), bus (pingpong_buf_if.slave).
// Option: PINGPONG_FLUSH_EN adds flush, committing a partially written bank early.
module pingpong_buf
    import pingpong_pkg::*;
#(
    parameter int DATA_W = PP_DATA_W,
    parameter int DEPTH  = PP_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    pingpong_buf_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    bank_state_t       state [2];
    logic [AW:0]       len   [2];
    logic              wbank;
    logic              rbank;
    logic [AW-1:0]     wcnt;
    logic [AW-1:0]     rcnt;

    logic              wr_fire;
    logic              rd_fire;
    logic              rd_last_i;
    logic              commit;
    logic              flush_commit;
    logic [AW:0]       commit_len;
    logic [DATA_W-1:0] rdata [2];

    // Handshake flags come purely from registered state.
    assign bus.wr_ready  = (state[wbank] != BANK_FULL);
    assign bus.rd_valid  = (state[rbank] == BANK_FULL);
    assign rd_last_i     = bus.rd_valid && ({1'b0, rcnt} == (len[rbank] - (AW+1)'(1)));
    assign bus.rd_last   = rd_last_i;
    assign bus.rd_data   = rdata[rbank];
    assign bus.bank_full = {state[1] == BANK_FULL, state[0] == BANK_FULL};

    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign rd_fire = bus.rd_valid && bus.rd_ready;

`ifdef PINGPONG_FLUSH_EN
    // An empty write bank has nothing to commit unless a word lands this same cycle.
    assign flush_commit = bus.flush && bus.wr_ready && (wr_fire || (wcnt != '0));
`else
    assign flush_commit = 1'b0;
`endif

    assign commit     = (wr_fire && (wcnt == AW'(DEPTH - 1))) || flush_commit;
    // Words already in the bank plus the one written this cycle; equals DEPTH on a full commit.
    assign commit_len = {1'b0, wcnt} + {{AW{1'b0}}, wr_fire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                state[b] <= BANK_EMPTY;
                len[b]   <= '0;
            end
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
        end else begin
            // Writer only touches a non-FULL bank and reader only a FULL one,
            // so the two branches never target the same bank.
            for (int b = 0; b < 2; b++) begin
                if (commit && (wbank == 1'(b))) begin
                    state[b] <= BANK_FULL;
                    len[b]   <= commit_len;
                end else if (wr_fire && (wbank == 1'(b))) begin
                    state[b] <= BANK_FILL;
                end else if (rd_fire && rd_last_i && (rbank == 1'(b))) begin
                    state[b] <= BANK_EMPTY;
                end
            end

            if (commit) begin
                wbank <= ~wbank;
                wcnt  <= '0;
            end else if (wr_fire) begin
                wcnt  <= wcnt + AW'(1);
            end

            if (rd_fire) begin
                if (rd_last_i) begin
                    rbank <= ~rbank;
                    rcnt  <= '0;
                end else begin
                    rcnt  <= rcnt + AW'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pingpong_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_fire && (wbank == 1'(g))),
            .waddr (wcnt),
            .wdata (bus.wr_data),
            .raddr (rcnt),
            .rdata (rdata[g])
        );
    end

endmodule

// File: tb/tb_pingpong_buf.sv
// Purpose: directed self-checking bench for pingpong_buf (DATA_W=16, DEPTH=8).
// Latency: n/a.
// Backpressure: n/a.
// Covers PINGPONG_FLUSH_EN scenarios only when that macro is defined.
module tb_pingpong_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pingpong_buf_if #(.DATA_W(16)) bus ();

    pingpong_buf #(
        .DATA_W (16),
        .DEPTH  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"},  32'(bus.wr_ready),  1);
        chk({tag, "_rd_valid"},  32'(bus.rd_valid),  0);
        chk({tag, "_rd_last"},   32'(bus.rd_last),   0);
        chk({tag, "_bank_full"}, 32'(bus.bank_full), 0);
        chk({tag, "_rd_data"},   32'(bus.rd_data),   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q [$];
        logic [15:0] e;
        int          nrd;

        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
`ifdef PINGPONG_FLUSH_EN
        bus.flush    = 1'b0;
`endif

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Fill bank 0 with 0x0001..0x0008, consumer idle
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("s1_not_yet_valid", 32'(bus.rd_valid), 0);
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'(i + 1);
            cyc();
        end
        chk("s1_bank_full", 32'(bus.bank_full), 'h1);
        chk("s1_rd_valid",  32'(bus.rd_valid),  1);
        chk("s1_rd_data",   32'(bus.rd_data),   'h0001);
        chk("s1_wr_ready",  32'(bus.wr_ready),  1);
        chk("s1_rd_last",   32'(bus.rd_last),   0);

        // Fill bank 1 with 0x0011..0x0018 -> both full
        for (int i = 0; i < 8; i++) begin
            bus.wr_data = 16'('h11 + i);
            cyc();
        end
        chk("s2_bank_full", 32'(bus.bank_full), 'h3);
        chk("s2_wr_ready",  32'(bus.wr_ready),  0);

        // 17th word offered while stalled
        bus.wr_data = 16'h0099;
        cyc();
        cyc();
        chk("s2_held_wr_ready",  32'(bus.wr_ready),  0);
        chk("s2_held_bank_full", 32'(bus.bank_full), 'h3);
        chk("s2_held_rd_data",   32'(bus.rd_data),   'h0001);

        // Drain bank 0; writer stays blocked until the last word leaves
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("s2_b0_data",     32'(bus.rd_data),  32'(k + 1));
            chk("s2_b0_last",     32'(bus.rd_last),  (k == 7) ? 1 : 0);
            chk("s2_b0_wr_ready", 32'(bus.wr_ready), 0);
            cyc();
        end
        chk("s2_after_b0_bank_full", 32'(bus.bank_full), 'h2);
        chk("s2_after_b0_wr_ready",  32'(bus.wr_ready),  1);
        chk("s2_after_b0_rd_data",   32'(bus.rd_data),   'h0011);
        bus.wr_valid = 1'b0;

        // Drain bank 1; the stalled 0x0099 must never have been stored
        for (int k = 0; k < 8; k++) begin
            chk("s2_b1_data", 32'(bus.rd_data), 32'('h11 + k));
            chk("s2_b1_last", 32'(bus.rd_last), (k == 7) ? 1 : 0);
            cyc();
        end
        chk("s2_end_rd_valid",  32'(bus.rd_valid),  0);
        chk("s2_end_bank_full", 32'(bus.bank_full), 0);
        chk("s2_end_wr_ready",  32'(bus.wr_ready),  1);

        // Streaming: write and read every cycle for 64 cycles
        nrd = 0;
        for (int i = 0; i < 64; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'('h100 + i);
            bus.rd_ready = 1'b1;
            chk("s3_wr_ready", 32'(bus.wr_ready), 1);
            if (i >= 8) chk("s3_no_gap", 32'(bus.rd_valid), 1);
            if (i == 15) chk("s3_turn_before", 32'(bus.bank_full), 'h1);
            if (i == 16) chk("s3_turn_after",  32'(bus.bank_full), 'h2);
            if (bus.wr_valid && bus.wr_ready) q.push_back(bus.wr_data);
            if (bus.rd_valid && bus.rd_ready) begin
                if (q.size() > 0) e = q.pop_front();
                else              e = 'x;
                chk("s3_data", 32'(bus.rd_data), 32'(e));
                chk("s3_last", 32'(bus.rd_last), (nrd % 8 == 7) ? 1 : 0);
                nrd++;
            end
            cyc();
        end
        bus.wr_valid = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (bus.rd_valid) begin
                if (q.size() > 0) e = q.pop_front();
                else              e = 'x;
                chk("s3_tail_data", 32'(bus.rd_data), 32'(e));
                chk("s3_tail_last", 32'(bus.rd_last), (nrd % 8 == 7) ? 1 : 0);
                nrd++;
            end
            cyc();
        end
        chk("s3_read_count", 32'(nrd),            64);
        chk("s3_queue_left", 32'(q.size()),       0);
        chk("s3_end_valid",  32'(bus.rd_valid),   0);

`ifdef PINGPONG_FLUSH_EN
        // Partial bank committed by flush
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'('hA0 + i);
            cyc();
        end
        bus.wr_valid = 1'b0;
        chk("fl_pre_bank_full", 32'(bus.bank_full), 0);
        chk("fl_pre_rd_valid",  32'(bus.rd_valid),  0);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("fl_bank_full", 32'(bus.bank_full), 'h1);
        chk("fl_rd_valid",  32'(bus.rd_valid),  1);
        chk("fl_rd_last0",  32'(bus.rd_last),   0);
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("fl_data", 32'(bus.rd_data), 32'('hA0 + k));
            chk("fl_last", 32'(bus.rd_last), (k == 2) ? 1 : 0);
            cyc();
        end
        bus.rd_ready = 1'b0;
        chk("fl_drained", 32'(bus.bank_full), 0);

        // Flush on an empty write bank does nothing
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("fl_empty_bank_full", 32'(bus.bank_full), 0);
        chk("fl_empty_rd_valid",  32'(bus.rd_valid),  0);
        chk("fl_empty_wr_ready",  32'(bus.wr_ready),  1);
`endif

        // Reset with both banks full, mid-read
        bus.rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'('h200 + i);
            cyc();
        end
        bus.wr_valid = 1'b0;
        chk("r_both_full", 32'(bus.bank_full), 'h3);
        bus.rd_ready = 1'b1;
        cyc();
        cyc();
        bus.rd_ready = 1'b0;
        chk("r_mid_read_data", 32'(bus.rd_data), 'h202);
        rst = 1'b1;
        #2;
        chk_reset_outputs("r_async");
        cyc();
        chk_reset_outputs("r_held");
        rst = 1'b0;

        // Fresh fill after reset behaves like the first one
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'('h31 + i);
            cyc();
        end
        bus.wr_valid = 1'b0;
        chk("r2_bank_full", 32'(bus.bank_full), 'h1);
        chk("r2_rd_valid",  32'(bus.rd_valid),  1);
        chk("r2_rd_data",   32'(bus.rd_data),   'h31);
        chk("r2_wr_ready",  32'(bus.wr_ready),  1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
